// File: rtl/iguana_pkg.sv
// Shared types, register map and reset values for the Hyperbus configuration
// register block.
package iguana_pkg;

  localparam int unsigned HypNumChips     = 2;
  localparam int unsigned HypRstChipBytes = 8192;
  localparam int unsigned HypAddrWidth    = 48;
  localparam int unsigned HypHiWidth      = HypAddrWidth - 32;

  typedef struct packed {
    logic [31:0]             idx;
    logic [HypAddrWidth-1:0] start_addr;
    logic [HypAddrWidth-1:0] end_addr;
  } hyper_addr_rule_t;

  typedef struct packed {
    logic [3:0]  latency;
    logic        add_lat;
    logic [15:0] burst_max;
    logic [3:0]  rw_recovery;
    logic [3:0]  rx_delay;
    logic [3:0]  tx_delay;
    logic [4:0]  addr_msb;
  } hyper_cfg_t;

  typedef enum logic [1:0] {
    CommitIdle  = 2'd0,
    CommitCheck = 2'd1,
    CommitWait  = 2'd2,
    CommitApply = 2'd3
  } commit_state_e;

  localparam logic [7:0] RegLatency    = 8'h00;
  localparam logic [7:0] RegAddLat     = 8'h04;
  localparam logic [7:0] RegBurstMax   = 8'h08;
  localparam logic [7:0] RegRwRecovery = 8'h0C;
  localparam logic [7:0] RegRxDelay    = 8'h10;
  localparam logic [7:0] RegTxDelay    = 8'h14;
  localparam logic [7:0] RegAddrMsb    = 8'h18;
  localparam logic [7:0] RegCommit     = 8'h20;
  localparam logic [7:0] RegStatus     = 8'h24;
  localparam logic [7:0] RegRuleBase   = 8'h40;

  localparam logic [1:0] RuleStartLo = 2'd0;
  localparam logic [1:0] RuleStartHi = 2'd1;
  localparam logic [1:0] RuleEndLo   = 2'd2;
  localparam logic [1:0] RuleEndHi   = 2'd3;

  localparam logic [3:0]  RstLatency    = 4'd6;
  localparam logic        RstAddLat     = 1'b1;
  localparam logic [15:0] RstBurstMax   = 16'd350;
  localparam logic [3:0]  RstRwRecovery = 4'd6;
  localparam logic [3:0]  RstRxDelay    = 4'd8;
  localparam logic [3:0]  RstTxDelay    = 4'd8;

  function automatic hyper_cfg_t hyper_rst_cfg(input int unsigned chip_bytes);
    hyper_cfg_t cfg;
    cfg.latency     = RstLatency;
    cfg.add_lat     = RstAddLat;
    cfg.burst_max   = RstBurstMax;
    cfg.rw_recovery = RstRwRecovery;
    cfg.rx_delay    = RstRxDelay;
    cfg.tx_delay    = RstTxDelay;
    cfg.addr_msb    = 5'($clog2(chip_bytes));
    return cfg;
  endfunction

  function automatic hyper_addr_rule_t hyper_rst_rule(input int unsigned chip,
                                                      input logic [HypAddrWidth-1:0] mem_base,
                                                      input int unsigned chip_bytes);
    hyper_addr_rule_t        rule;
    logic [HypAddrWidth-1:0] size;
    size            = HypAddrWidth'(chip_bytes);
    rule.idx        = 32'(chip);
    rule.start_addr = mem_base + HypAddrWidth'(chip) * size;
    rule.end_addr   = rule.start_addr + size;
    return rule;
  endfunction

  // Byte-lane merge: strobed lanes take new data, the rest keep the old value.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/iguana_hyper_cfg_commit.sv
// Commit sequencer: validates the shadow rules, waits for an idle PHY, then
// issues a single-cycle apply.
module iguana_hyper_cfg_commit
  import iguana_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic commit_i,
  input  logic rules_ok_i,
  input  logic phy_idle_i,
  output logic pending_o,
  output logic apply_o,
  output logic err_set_o
);

  commit_state_e r_state;
  commit_state_e w_next;
  logic          r_pending;
  logic          r_apply;

  // State register plus registered copies of the state-decoded outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= CommitIdle;
      r_pending <= 1'b0;
      r_apply   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pending <= (w_next != CommitIdle);
      r_apply   <= (w_next == CommitApply);
    end
  end

  // Next-state logic; phy idle is only looked at while waiting.
  always_comb begin
    w_next    = r_state;
    err_set_o = 1'b0;
    case (r_state)
      CommitIdle: begin
        if (commit_i) w_next = CommitCheck;
        else          w_next = CommitIdle;
      end
      CommitCheck: begin
        if (rules_ok_i) begin
          w_next = CommitWait;
        end else begin
          w_next    = CommitIdle;
          err_set_o = 1'b1;
        end
      end
      CommitWait: begin
        if (phy_idle_i) w_next = CommitApply;
        else            w_next = CommitWait;
      end
      CommitApply: w_next = CommitIdle;
      default:     w_next = CommitIdle;
    endcase
  end

  assign pending_o = r_pending;
  assign apply_o   = r_apply;

endmodule

// File: rtl/iguana_hyper_cfg_regs.sv
// Hyperbus PHY configuration registers: shadow copies written over the register
// bus, transferred to the live outputs by an explicit commit.
module iguana_hyper_cfg_regs
  import iguana_pkg::*;
#(
  parameter int unsigned             NumChips  = HypNumChips,
  parameter logic [HypAddrWidth-1:0] MemBase   = 48'h0000_8000_0000,
  parameter int unsigned             ChipBytes = HypRstChipBytes,
  parameter int unsigned             AddrWidth = HypAddrWidth
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            reg_valid_i,
  input  logic                            reg_write_i,
  input  logic [AddrWidth-1:0]            reg_addr_i,
  input  logic [31:0]                     reg_wdata_i,
  input  logic [3:0]                      reg_wstrb_i,
  output logic                            reg_ready_o,
  output logic [31:0]                     reg_rdata_o,
  output logic                            reg_error_o,
  input  logic                            phy_idle_i,
  output hyper_cfg_t                      cfg_o,
  output hyper_addr_rule_t [NumChips-1:0] addr_rules_o,
  output logic                            cfg_update_o
);

  hyper_cfg_t                      r_cfg;
  hyper_cfg_t                      r_live_cfg;
  hyper_addr_rule_t [NumChips-1:0] r_rules;
  hyper_addr_rule_t [NumChips-1:0] r_live_rules;
  logic                            r_err;

  logic [7:0]              w_off;
  logic [3:0]              w_chip;
  logic [1:0]              w_field;
  logic                    w_is_rule;
  logic                    w_chip_ok;
  logic                    w_error;
  logic                    w_stall;
  logic                    w_wr_en;
  logic                    w_commit;
  logic                    w_rules_ok;
  logic                    w_pending;
  logic                    w_apply;
  logic                    w_err_set;
  logic [31:0]             w_rd_raw;
  logic [31:0]             w_wval;
  logic [HypAddrWidth-1:0] w_sel_start;
  logic [HypAddrWidth-1:0] w_sel_end;
  logic                    w_unused;

  assign w_unused  = ^reg_addr_i[AddrWidth-1:8];
  assign w_off     = reg_addr_i[7:0];
  assign w_is_rule = (w_off >= RegRuleBase);
  assign w_chip    = w_off[7:4] - 4'd4;
  assign w_field   = w_off[3:2];
  assign w_chip_ok = ({28'd0, w_chip} < NumChips);

  // Address decode and read mux; the raw value also seeds the strobe merge.
  always_comb begin
    w_sel_start = r_rules[0].start_addr;
    w_sel_end   = r_rules[0].end_addr;
    for (int c = 0; c < NumChips; c++) begin
      w_sel_start = (w_chip == 4'(c)) ? r_rules[c].start_addr : w_sel_start;
      w_sel_end   = (w_chip == 4'(c)) ? r_rules[c].end_addr   : w_sel_end;
    end
    w_rd_raw = 32'd0;
    w_error  = 1'b0;
    if (w_off[1:0] != 2'b00) begin
      w_error = 1'b1;
    end else if (w_is_rule) begin
      if (w_chip_ok) begin
        case (w_field)
          RuleStartLo: w_rd_raw = w_sel_start[31:0];
          RuleStartHi: w_rd_raw = {{(32-HypHiWidth){1'b0}}, w_sel_start[HypAddrWidth-1:32]};
          RuleEndLo:   w_rd_raw = w_sel_end[31:0];
          RuleEndHi:   w_rd_raw = {{(32-HypHiWidth){1'b0}}, w_sel_end[HypAddrWidth-1:32]};
          default:     w_rd_raw = 32'd0;
        endcase
      end else begin
        w_error = 1'b1;
      end
    end else begin
      case (w_off)
        RegLatency:    w_rd_raw = {28'd0, r_cfg.latency};
        RegAddLat:     w_rd_raw = {31'd0, r_cfg.add_lat};
        RegBurstMax:   w_rd_raw = {16'd0, r_cfg.burst_max};
        RegRwRecovery: w_rd_raw = {28'd0, r_cfg.rw_recovery};
        RegRxDelay:    w_rd_raw = {28'd0, r_cfg.rx_delay};
        RegTxDelay:    w_rd_raw = {28'd0, r_cfg.tx_delay};
        RegAddrMsb:    w_rd_raw = {27'd0, r_cfg.addr_msb};
        RegCommit:     w_rd_raw = {31'd0, w_pending};
        RegStatus: begin
          w_rd_raw = {29'd0, r_err, phy_idle_i, w_pending};
          w_error  = reg_write_i;
        end
        default:       w_error = 1'b1;
      endcase
    end
  end

  // Writes are held off while a commit is in flight so shadow state is frozen.
  assign w_stall     = reg_write_i & w_pending;
  assign reg_ready_o = reg_valid_i & ~w_stall;
  assign reg_error_o = w_error;
  assign reg_rdata_o = w_error ? 32'd0 : w_rd_raw;
  assign w_wr_en     = reg_valid_i & reg_write_i & ~w_stall & ~w_error;
  assign w_wval      = strb_merge(w_rd_raw, reg_wdata_i, reg_wstrb_i);
  assign w_commit    = w_wr_en & (w_off == RegCommit) & reg_wstrb_i[0] & reg_wdata_i[0];

  // A rule is usable only if it spans a non-empty range.
  always_comb begin
    w_rules_ok = 1'b1;
    for (int c = 0; c < NumChips; c++) begin
      w_rules_ok = w_rules_ok & (r_rules[c].end_addr > r_rules[c].start_addr);
    end
  end

  iguana_hyper_cfg_commit u_commit (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .commit_i   (w_commit),
    .rules_ok_i (w_rules_ok),
    .phy_idle_i (phy_idle_i),
    .pending_o  (w_pending),
    .apply_o    (w_apply),
    .err_set_o  (w_err_set)
  );

  // Shadow register file.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cfg <= hyper_rst_cfg(ChipBytes);
      for (int c = 0; c < NumChips; c++) begin
        r_rules[c] <= hyper_rst_rule(c, MemBase, ChipBytes);
      end
    end else if (w_wr_en) begin
      if (w_is_rule) begin
        for (int c = 0; c < NumChips; c++) begin
          if (w_chip == 4'(c)) begin
            case (w_field)
              RuleStartLo: r_rules[c].start_addr[31:0]              <= w_wval;
              RuleStartHi: r_rules[c].start_addr[HypAddrWidth-1:32] <= w_wval[HypHiWidth-1:0];
              RuleEndLo:   r_rules[c].end_addr[31:0]                <= w_wval;
              RuleEndHi:   r_rules[c].end_addr[HypAddrWidth-1:32]   <= w_wval[HypHiWidth-1:0];
              default:     r_rules[c] <= r_rules[c];
            endcase
          end
        end
      end else begin
        case (w_off)
          RegLatency:    r_cfg.latency     <= w_wval[3:0];
          RegAddLat:     r_cfg.add_lat     <= w_wval[0];
          RegBurstMax:   r_cfg.burst_max   <= w_wval[15:0];
          RegRwRecovery: r_cfg.rw_recovery <= w_wval[3:0];
          RegRxDelay:    r_cfg.rx_delay    <= w_wval[3:0];
          RegTxDelay:    r_cfg.tx_delay    <= w_wval[3:0];
          RegAddrMsb:    r_cfg.addr_msb    <= w_wval[4:0];
          default:       r_cfg <= r_cfg;
        endcase
      end
    end
  end

  // Sticky error: set by a failed rule check, cleared by the next commit write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (w_commit) begin
      r_err <= 1'b0;
    end
  end

  // Live copy seen by the controller, replaced atomically on apply.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_live_cfg <= hyper_rst_cfg(ChipBytes);
      for (int c = 0; c < NumChips; c++) begin
        r_live_rules[c] <= hyper_rst_rule(c, MemBase, ChipBytes);
      end
    end else if (w_apply) begin
      r_live_cfg   <= r_cfg;
      r_live_rules <= r_rules;
    end
  end

  assign cfg_o        = r_live_cfg;
  assign addr_rules_o = r_live_rules;
  assign cfg_update_o = w_apply;

endmodule

// File: tb/tb_iguana_hyper_cfg_regs.sv
// Directed bench for iguana_hyper_cfg_regs: register map table plus commit,
// stall, rule-error and mid-commit reset sequences.
module tb_iguana_hyper_cfg_regs;
  import iguana_pkg::*;

  localparam int unsigned NChips = 2;
  localparam logic [47:0] WinBase = 48'h0000_4000_0000;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          reg_valid;
  logic                          reg_write;
  logic [47:0]                   reg_addr;
  logic [31:0]                   reg_wdata;
  logic [3:0]                    reg_wstrb;
  logic                          reg_ready;
  logic [31:0]                   reg_rdata;
  logic                          reg_error;
  logic                          phy_idle;
  hyper_cfg_t                    cfg;
  hyper_addr_rule_t [NChips-1:0] rules;
  logic                          cfg_update;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iguana_hyper_cfg_regs #(
    .NumChips  (NChips),
    .MemBase   (48'h0000_8000_0000),
    .ChipBytes (8192),
    .AddrWidth (48)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .reg_valid_i  (reg_valid),
    .reg_write_i  (reg_write),
    .reg_addr_i   (reg_addr),
    .reg_wdata_i  (reg_wdata),
    .reg_wstrb_i  (reg_wstrb),
    .reg_ready_o  (reg_ready),
    .reg_rdata_o  (reg_rdata),
    .reg_error_o  (reg_error),
    .phy_idle_i   (phy_idle),
    .cfg_o        (cfg),
    .addr_rules_o (rules),
    .cfg_update_o (cfg_update)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  off;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One bus access; waits is the number of stalled cycles (bounded).
  task automatic bus(input logic wr, input logic [7:0] off, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd, output logic er,
                     output int waits);
    @(negedge clk);
    reg_valid = 1'b1;
    reg_write = wr;
    reg_addr  = WinBase + {40'd0, off};
    reg_wdata = wd;
    reg_wstrb = st;
    waits     = 0;
    #1;
    while (!reg_ready && waits < 100) begin
      @(negedge clk);
      #1;
      waits++;
    end
    rd = reg_rdata;
    er = reg_error;
    @(posedge clk);
    #1;
    reg_valid = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic add(input logic wr, input logic [7:0] off, input logic [31:0] wd,
                     input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.wr = wr; v.off = off; v.wd = wd; v.st = st; v.exp_rd = exp_rd; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          waits;
    int          pulse_at;
    int          pulses;
    int          stalls;
    logic        lat_ok;
    logic        seen_upd;
    logic        acc;
    hyper_cfg_t  exp_rst_cfg;

    exp_rst_cfg = '{latency: 4'd6, add_lat: 1'b1, burst_max: 16'd350, rw_recovery: 4'd6,
                    rx_delay: 4'd8, tx_delay: 4'd8, addr_msb: 5'd13};

    add(1'b0, 8'h00, 32'd0, 4'hF, 32'd6, 1'b0);
    add(1'b0, 8'h04, 32'd0, 4'hF, 32'd1, 1'b0);
    add(1'b0, 8'h08, 32'd0, 4'hF, 32'd350, 1'b0);
    add(1'b0, 8'h0C, 32'd0, 4'hF, 32'd6, 1'b0);
    add(1'b0, 8'h10, 32'd0, 4'hF, 32'd8, 1'b0);
    add(1'b0, 8'h14, 32'd0, 4'hF, 32'd8, 1'b0);
    add(1'b0, 8'h18, 32'd0, 4'hF, 32'd13, 1'b0);
    add(1'b0, 8'h40, 32'd0, 4'hF, 32'h8000_0000, 1'b0);
    add(1'b0, 8'h44, 32'd0, 4'hF, 32'h0000_0000, 1'b0);
    add(1'b0, 8'h48, 32'd0, 4'hF, 32'h8000_2000, 1'b0);
    add(1'b0, 8'h50, 32'd0, 4'hF, 32'h8000_2000, 1'b0);
    add(1'b0, 8'h58, 32'd0, 4'hF, 32'h8000_4000, 1'b0);
    add(1'b0, 8'h20, 32'd0, 4'hF, 32'd0, 1'b0);
    add(1'b0, 8'h24, 32'd0, 4'hF, 32'd2, 1'b0);
    add(1'b0, 8'h30, 32'd0, 4'hF, 32'd0, 1'b1);
    add(1'b1, 8'h24, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1);
    add(1'b0, 8'h24, 32'd0, 4'hF, 32'd2, 1'b0);
    add(1'b0, 8'h60, 32'd0, 4'hF, 32'd0, 1'b1);
    add(1'b1, 8'h60, 32'h1234_5678, 4'hF, 32'd0, 1'b1);
    add(1'b0, 8'h1C, 32'd0, 4'hF, 32'd0, 1'b1);
    add(1'b1, 8'h08, 32'hFFFF_1234, 4'b0001, 32'd0, 1'b0);
    add(1'b0, 8'h08, 32'd0, 4'hF, 32'h0000_0134, 1'b0);
    add(1'b1, 8'h44, 32'hFFFF_ABCD, 4'hF, 32'd0, 1'b0);
    add(1'b0, 8'h44, 32'd0, 4'hF, 32'h0000_ABCD, 1'b0);
    add(1'b1, 8'h44, 32'd0, 4'hF, 32'd0, 1'b0);
    add(1'b0, 8'h44, 32'd0, 4'hF, 32'd0, 1'b0);
    add(1'b1, 8'h04, 32'hFFFF_FFFE, 4'hF, 32'd0, 1'b0);
    add(1'b0, 8'h04, 32'd0, 4'hF, 32'd0, 1'b0);
    add(1'b1, 8'h04, 32'd1, 4'hF, 32'd0, 1'b0);
    add(1'b0, 8'h04, 32'd0, 4'hF, 32'd1, 1'b0);

    rst = 1'b1; reg_valid = 1'b0; reg_write = 1'b0; reg_addr = 48'd0;
    reg_wdata = 32'd0; reg_wstrb = 4'h0; phy_idle = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_in_reset", cfg, exp_rst_cfg);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_cfg", cfg, exp_rst_cfg);
    chk("rst_rule0_start", rules[0].start_addr, 48'h0000_8000_0000);
    chk("rst_rule0_end", rules[0].end_addr, 48'h0000_8000_2000);
    chk("rst_rule1_start", rules[1].start_addr, 48'h0000_8000_2000);
    chk("rst_rule1_end", rules[1].end_addr, 48'h0000_8000_4000);
    chk("rst_update", cfg_update, 1'b0);
    chk("rst_ready_idle", reg_ready, 1'b0);

    foreach (vecs[i]) begin
      bus(vecs[i].wr, vecs[i].off, vecs[i].wd, vecs[i].st, rd, er, waits);
      chk($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
      chk($sformatf("vec%0d_wait", i), waits, 0);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end
    chk("live_burst_uncommitted", cfg.burst_max, 16'd350);

    // Commit with idle PHY: pulse two cycles after CHECK, live changes after it.
    bus(1'b1, 8'h00, 32'd9, 4'hF, rd, er, waits);
    bus(1'b1, 8'h20, 32'd1, 4'hF, rd, er, waits);
    pulse_at = -1; pulses = 0; lat_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (pulse_at < 0 && cfg.latency != 4'd6) lat_ok = 1'b0;
      if (cfg_update) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
      @(posedge clk);
      #1;
    end
    chk("commit_pulse_cycle", pulse_at, 2);
    chk("commit_pulse_count", pulses, 1);
    chk("commit_latency_before", lat_ok, 1'b1);
    chk("commit_latency_after", cfg.latency, 4'd9);
    chk("commit_burst_after", cfg.burst_max, 16'h0134);

    // Commit held off by a busy PHY; a write stalls until the apply finishes.
    phy_idle = 1'b0;
    bus(1'b1, 8'h08, 32'd100, 4'hF, rd, er, waits);
    bus(1'b1, 8'h20, 32'd1, 4'hF, rd, er, waits);
    bus(1'b0, 8'h24, 32'd0, 4'hF, rd, er, waits);
    chk("wait_status", rd, 32'd1);
    chk("wait_read_not_stalled", waits, 0);
    @(negedge clk);
    reg_valid = 1'b1; reg_write = 1'b1; reg_addr = WinBase + 48'h0C;
    reg_wdata = 32'd3; reg_wstrb = 4'hF;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!reg_ready) stalls++;
      @(negedge clk);
    end
    chk("stall_cycles", stalls, 20);
    chk("stall_burst_live", cfg.burst_max, 16'h0134);
    phy_idle = 1'b1;
    seen_upd = 1'b0; acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      #1;
      if (cfg_update) seen_upd = 1'b1;
      if (reg_ready) acc = 1'b1;
      else @(negedge clk);
    end
    @(posedge clk);
    #1;
    reg_valid = 1'b0; reg_write = 1'b0;
    chk("stall_write_accepted", acc, 1'b1);
    chk("stall_update_seen", seen_upd, 1'b1);
    chk("stall_burst_applied", cfg.burst_max, 16'd100);
    bus(1'b0, 8'h0C, 32'd0, 4'hF, rd, er, waits);
    chk("stall_write_landed", rd, 32'd3);
    chk("stall_rwrec_live", cfg.rw_recovery, 4'd6);

    // Empty rule: commit rejected, ERR sticky until the next commit write.
    bus(1'b1, 8'h58, 32'h8000_2000, 4'hF, rd, er, waits);
    bus(1'b1, 8'h20, 32'd1, 4'hF, rd, er, waits);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (cfg_update) pulses++;
      @(posedge clk);
      #1;
    end
    chk("rule_err_no_update", pulses, 0);
    bus(1'b0, 8'h24, 32'd0, 4'hF, rd, er, waits);
    chk("rule_err_status", rd, 32'd6);
    chk("rule_err_live_end", rules[1].end_addr, 48'h0000_8000_4000);
    bus(1'b1, 8'h58, 32'h8000_4000, 4'hF, rd, er, waits);
    bus(1'b1, 8'h20, 32'd1, 4'hF, rd, er, waits);
    repeat (6) @(posedge clk);
    #1;
    bus(1'b0, 8'h24, 32'd0, 4'hF, rd, er, waits);
    chk("rule_err_cleared", rd, 32'd2);

    // Reset while waiting for the PHY, then a fresh commit.
    phy_idle = 1'b0;
    bus(1'b1, 8'h00, 32'd12, 4'hF, rd, er, waits);
    bus(1'b1, 8'h20, 32'd1, 4'hF, rd, er, waits);
    repeat (3) @(posedge clk);
    #1;
    bus(1'b0, 8'h24, 32'd0, 4'hF, rd, er, waits);
    chk("midrst_pending_before", rd, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_cfg", cfg, exp_rst_cfg);
    chk("midrst_update", cfg_update, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus(1'b0, 8'h24, 32'd0, 4'hF, rd, er, waits);
    chk("midrst_status", rd, 32'd0);
    bus(1'b0, 8'h00, 32'd0, 4'hF, rd, er, waits);
    chk("midrst_shadow_latency", rd, 32'd6);
    chk("midrst_rule0_start", rules[0].start_addr, 48'h0000_8000_0000);
    phy_idle = 1'b1;
    bus(1'b1, 8'h00, 32'd5, 4'hF, rd, er, waits);
    bus(1'b1, 8'h20, 32'd1, 4'hF, rd, er, waits);
    pulse_at = -1;
    for (int i = 0; i < 8; i++) begin
      if (cfg_update && pulse_at < 0) pulse_at = i;
      @(posedge clk);
      #1;
    end
    chk("recommit_pulse_cycle", pulse_at, 2);
    chk("recommit_latency", cfg.latency, 4'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
